// File: rtl/fpsqrt_sp_pkg.sv
// ============================================================================
// Module : fpsqrt_sp_pkg
// Brief  : FloPoCo single-precision result types and IEEE-754 conversion.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fpsqrt_sp_pkg;

    typedef enum logic [1:0] {
        EXN_ZERO   = 2'b00,
        EXN_NORMAL = 2'b01,
        EXN_INF    = 2'b10,
        EXN_NAN    = 2'b11
    } flopoco_exn_t;

    typedef struct packed {
        flopoco_exn_t exn;
        logic         sign;
        logic [7:0]   exp;
        logic [22:0]  frac;
    } flopoco_sp_t;

    localparam logic [31:0] IEEE_QNAN = 32'h7FC00000;

    function automatic logic [31:0] flopoco_to_ieee(input flopoco_sp_t r);
        logic [31:0] res;
        case (r.exn)
            EXN_ZERO:   res = {r.sign, 31'b0};
            EXN_NORMAL: res = {r.sign, r.exp, r.frac};
            EXN_INF:    res = {r.sign, 8'hFF, 23'b0};
            default:    res = IEEE_QNAN;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpsqrt_sp_collect_if.sv
// ============================================================================
// Module : fpsqrt_sp_collect_if
// Brief  : Operand/ce/result bundle between core, collector and consumer.
//          out_nv exists only when FPSQRT_COLLECT_FLAGS_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fpsqrt_sp_collect_if;

    logic        in_valid;
    logic        in_ready;
    logic        ce;
    logic [33:0] core_r;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef FPSQRT_COLLECT_FLAGS_EN
    logic        out_nv;

    modport slave  (input  in_valid, core_r, out_ready,
                    output in_ready, ce, out_valid, out_data, out_nv);
    modport master (output in_valid, core_r, out_ready,
                    input  in_ready, ce, out_valid, out_data, out_nv);
`else
    modport slave  (input  in_valid, core_r, out_ready,
                    output in_ready, ce, out_valid, out_data);
    modport master (output in_valid, core_r, out_ready,
                    input  in_ready, ce, out_valid, out_data);
`endif

endinterface

`default_nettype wire

// File: rtl/fpsqrt_sp_res_fifo.sv
// ============================================================================
// Module : fpsqrt_sp_res_fifo
// Brief  : Synchronous result FIFO; push and pop may coincide when full.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fpsqrt_sp_res_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] wdata_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] rdata_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/fpsqrt_sp_collect.sv
// ============================================================================
// Module : fpsqrt_sp_collect
// Brief  : Result stage of the sqrt pipeline: slot tracking, core ce/stall,
//          FloPoCo->IEEE conversion, result FIFO. Option: FPSQRT_COLLECT_FLAGS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fpsqrt_sp_collect
    import fpsqrt_sp_pkg::*;
#(
    parameter int NUM_STAGES = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    fpsqrt_sp_collect_if.slave  bus
);

`ifdef FPSQRT_COLLECT_FLAGS_EN
    localparam int ENTRY_W = 33;
`else
    localparam int ENTRY_W = 32;
`endif

    logic [NUM_STAGES-1:0] vld_sr_q, vld_sr_d;
    logic                  live, fifo_full, fifo_empty, pop, push, ce;
    flopoco_sp_t           res;
    logic [ENTRY_W-1:0]    wdata, rdata;

    assign res  = flopoco_sp_t'(bus.core_r);
    assign live = vld_sr_q[NUM_STAGES-1];
    assign pop  = ~fifo_empty & bus.out_ready;
    // Freeze the core only when a live result has nowhere to go this cycle.
    assign ce   = ~(live & fifo_full & ~pop);
    assign push = ce & live;

    always_comb begin
        vld_sr_d = vld_sr_q;
        if (ce) vld_sr_d = (vld_sr_q << 1) | NUM_STAGES'(bus.in_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_sr_q <= '0;
        else        vld_sr_q <= vld_sr_d;
    end

`ifdef FPSQRT_COLLECT_FLAGS_EN
    assign wdata      = {res.exn == EXN_NAN, flopoco_to_ieee(res)};
    assign bus.out_nv = rdata[32];
`else
    assign wdata      = flopoco_to_ieee(res);
`endif

    fpsqrt_sp_res_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (pop),
        .rdata_o (rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.ce        = ce;
    assign bus.in_ready  = ce;
    assign bus.out_valid = ~fifo_empty;
    assign bus.out_data  = rdata[31:0];

endmodule

`default_nettype wire
